bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer.sv | 225 ++++++++++++++++++++++
 tb/tb_bus_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit machine timer (mtime/mtimecmp) with a level interrupt.
// Single-cycle request/response slave: every request is answered exactly one cycle later.
// Optional prescaler at offset 0x14 is compiled in only when BUS_TIMER_PRESCALER_EN is defined;
// without it every enabled cycle is a tick and 0x14 is unmapped.

module bus_timer #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic [AddressWidth-1:0]   addr_i,
    input  logic                      we_i,
    input  logic [DataWidth/8-1:0]    be_i,
    input  logic [DataWidth-1:0]      wdata_i,
    output logic                      rvalid_o,
    output logic [DataWidth-1:0]      rdata_o,
    output logic                      err_o,
    output logic                      timer_intr_o
);

    // Word index of each register (addr_i[4:2]).
    localparam logic [2:0] IdxMtimeLo    = 3'd0;
    localparam logic [2:0] IdxMtimeHi    = 3'd1;
    localparam logic [2:0] IdxMtimecmpLo = 3'd2;
    localparam logic [2:0] IdxMtimecmpHi = 3'd3;
    localparam logic [2:0] IdxCtrl       = 3'd4;
`ifdef BUS_TIMER_PRESCALER_EN
    localparam logic [2:0] IdxPrescale   = 3'd5;
`endif

    // Merge new data into old data one byte lane at a time.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Architectural state
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic                 ctrl_en_q, ctrl_en_d;
    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 intr_q, intr_d;

    // Decode
    logic [2:0]           reg_idx;
    logic                 hit;
    logic [31:0]          reg_rdata;
    logic                 wr_req;
    logic                 wr_mtime_lo, wr_mtime_hi;
    logic                 wr_mtimecmp_lo, wr_mtimecmp_hi;
    logic                 wr_ctrl;
    logic                 tick;

    // Only addr_i[4:2] is decoded; the remaining address bits are deliberately ignored.
    logic                 unused_addr;
    assign unused_addr = ^{addr_i[AddressWidth-1:5], addr_i[1:0]};

    assign reg_idx = addr_i[4:2];
    assign wr_req  = req_i & we_i;

    assign wr_mtime_lo    = wr_req & (reg_idx == IdxMtimeLo);
    assign wr_mtime_hi    = wr_req & (reg_idx == IdxMtimeHi);
    assign wr_mtimecmp_lo = wr_req & (reg_idx == IdxMtimecmpLo);
    assign wr_mtimecmp_hi = wr_req & (reg_idx == IdxMtimecmpHi);
    assign wr_ctrl        = wr_req & (reg_idx == IdxCtrl);

`ifdef BUS_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;
    logic        wr_prescale;

    assign wr_prescale = wr_req & (reg_idx == IdxPrescale);

    // A tick fires when the counter reaches PRESCALE; PRESCALE = 0 ticks every enabled cycle.
    assign tick = ctrl_en_q & (presc_cnt_q == prescale_q);

    // Prescaler register and its free-running counter; writing PRESCALE restarts the count.
    always_comb begin
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        if (wr_prescale) begin
            prescale_d[7:0]  = be_i[0] ? wdata_i[7:0]  : prescale_q[7:0];
            prescale_d[15:8] = be_i[1] ? wdata_i[15:8] : prescale_q[15:8];
            presc_cnt_d      = 16'd0;
        end else if (ctrl_en_q) begin
            if (presc_cnt_q == prescale_q) begin
                presc_cnt_d = 16'd0;
            end else begin
                presc_cnt_d = presc_cnt_q + 16'd1;
            end
        end
    end

    // Prescaler state, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prescale_q  <= 16'd0;
            presc_cnt_q <= 16'd0;
        end else begin
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end
`else
    assign tick = ctrl_en_q;
`endif

    // Read mux and hit detection for the request presented this cycle.
    always_comb begin
        hit       = 1'b0;
        reg_rdata = 32'd0;
        case (reg_idx)
            IdxMtimeLo: begin
                hit       = 1'b1;
                reg_rdata = mtime_q[31:0];
            end
            IdxMtimeHi: begin
                hit       = 1'b1;
                reg_rdata = mtime_q[63:32];
            end
            IdxMtimecmpLo: begin
                hit       = 1'b1;
                reg_rdata = mtimecmp_q[31:0];
            end
            IdxMtimecmpHi: begin
                hit       = 1'b1;
                reg_rdata = mtimecmp_q[63:32];
            end
            IdxCtrl: begin
                hit       = 1'b1;
                reg_rdata = {31'd0, ctrl_en_q};
            end
`ifdef BUS_TIMER_PRESCALER_EN
            IdxPrescale: begin
                hit       = 1'b1;
                reg_rdata = {16'd0, prescale_q};
            end
`endif
            default: begin
                hit       = 1'b0;
                reg_rdata = 32'd0;
            end
        endcase
    end

    // mtime: a software write to either half wins over the increment for that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime_d[31:0] = apply_be(mtime_q[31:0], wdata_i, be_i);
            end
            if (wr_mtime_hi) begin
                mtime_d[63:32] = apply_be(mtime_q[63:32], wdata_i, be_i);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtimecmp and CTRL byte-lane writes.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        ctrl_en_d  = ctrl_en_q;
        if (wr_mtimecmp_lo) begin
            mtimecmp_d[31:0] = apply_be(mtimecmp_q[31:0], wdata_i, be_i);
        end
        if (wr_mtimecmp_hi) begin
            mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], wdata_i, be_i);
        end
        if (wr_ctrl && be_i[0]) begin
            ctrl_en_d = wdata_i[0];
        end
    end

    // Response and interrupt next-state; reads return state sampled in the request cycle.
    always_comb begin
        rvalid_d = req_i;
        err_d    = req_i & ~hit;
        rdata_d  = '0;
        if (req_i && !we_i && hit) begin
            rdata_d = reg_rdata;
        end
        intr_d   = (mtime_q >= mtimecmp_q);
    end

    // Timer and response registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= {64{1'b1}};
            ctrl_en_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_en_q  <= ctrl_en_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            intr_q     <= intr_d;
        end
    end

    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign timer_intr_o = intr_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer. Builds with or without BUS_TIMER_PRESCALER_EN.

module tb_bus_timer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timer_intr_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] AMtimeLo    = 32'h00;
    localparam logic [31:0] AMtimeHi    = 32'h04;
    localparam logic [31:0] AMtimecmpLo = 32'h08;
    localparam logic [31:0] AMtimecmpHi = 32'h0C;
    localparam logic [31:0] ACtrl       = 32'h10;
    localparam logic [31:0] APrescale   = 32'h14;

    bus_timer #(
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .timer_intr_o (timer_intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at posedge+1, return the response sampled 1 ns after the next edge.
    task automatic bus(input logic we, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
        @(posedge clk_i);
        #1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = 32'h0;
        check("rvalid_resp", {31'd0, rvalid_o}, 32'd1);
        rd = rdata_o;
        er = err_o;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        logic        e;
        bus(1'b1, a, b, d, r, e);
        check("wr_err", {31'd0, e}, 32'd0);
        check("wr_rdata", r, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        bus(1'b0, a, 4'h0, 32'h0, r, e);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
        check(tag, r, exp);
    endtask

    task automatic unmapped(input string tag, input logic we, input logic [31:0] a);
        logic [31:0] r;
        logic        e;
        bus(we, a, 4'hF, 32'hDEAD_BEEF, r, e);
        check({tag, "_err"}, {31'd0, e}, 32'd1);
        check({tag, "_rdata"}, r, 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
        check("rvalid_idle", {31'd0, rvalid_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tmp_r;
        logic        tmp_e;

        rst_ni  = 1'b0;
        req_i   = 1'b0;
        addr_i  = 32'h0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Reset state
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_intr", {31'd0, timer_intr_o}, 32'd0);
        rd("rst_ctrl", ACtrl, 32'd0);
        rd("rst_cmp_lo", AMtimecmpLo, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", AMtimecmpHi, 32'hFFFF_FFFF);
        rd("rst_mtime_lo", AMtimeLo, 32'd0);
        idle_cycle();

        // Bus inputs without req_i have no effect
        addr_i  = ACtrl;
        we_i    = 1'b1;
        be_i    = 4'hF;
        wdata_i = 32'h1;
        idle_cycle();
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = 32'h0;
        rd("noreq_ctrl", ACtrl, 32'd0);

        // Enable, wait 10 cycles, read mtime; back-to-back reads
        wr(ACtrl, 32'h1, 4'hF);
        repeat (10) @(posedge clk_i);
        #1;
        rd("count10", AMtimeLo, 32'd10);
        rd("count11", AMtimeLo, 32'd11);
        rd("ctrl_rb", ACtrl, 32'd1);
        idle_cycle();

        // Carry from low to high word
        do_reset();
        wr(AMtimeHi, 32'h0, 4'hF);
        wr(AMtimeLo, 32'hFFFF_FFFE, 4'hF);
        wr(ACtrl, 32'h1, 4'hF);
        @(posedge clk_i);
        #1;
        wr(ACtrl, 32'h0, 4'hF);
        rd("carry_hi", AMtimeHi, 32'd1);
        rd("carry_lo", AMtimeLo, 32'd0);

        // 64-bit wrap: exactly one tick from all-ones
        wr(AMtimeLo, 32'hFFFF_FFFF, 4'hF);
        wr(AMtimeHi, 32'hFFFF_FFFF, 4'hF);
        wr(ACtrl, 32'h1, 4'hF);
        wr(ACtrl, 32'h0, 4'hF);
        rd("wrap_lo", AMtimeLo, 32'd0);
        rd("wrap_hi", AMtimeHi, 32'd0);

        // Interrupt rises the cycle after mtime reaches 0x20, falls after compare raised
        do_reset();
        wr(AMtimecmpLo, 32'h20, 4'hF);
        wr(AMtimecmpHi, 32'h0, 4'hF);
        wr(ACtrl, 32'h1, 4'hF);
        repeat (32) @(posedge clk_i);
        #1;
        check("intr_before", {31'd0, timer_intr_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("intr_rise", {31'd0, timer_intr_o}, 32'd1);
        wr(AMtimecmpLo, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk_i);
        #1;
        check("intr_fall", {31'd0, timer_intr_o}, 32'd0);

        // Unmapped offsets and byte-lane writes
        do_reset();
        unmapped("unmap_rd18", 1'b0, 32'h18);
        unmapped("unmap_rd1c", 1'b0, 32'h1C);
        unmapped("unmap_wr18", 1'b1, 32'h18);
        wr(AMtimecmpLo, 32'h0000_AB00, 4'b0010);
        rd("be_lane1", AMtimecmpLo, 32'hFFFF_ABFF);
        wr(AMtimecmpLo, 32'h1234_5678, 4'b0000);
        rd("be_none", AMtimecmpLo, 32'hFFFF_ABFF);

`ifdef BUS_TIMER_PRESCALER_EN
        // PRESCALE = 3: one tick per 4 enabled cycles
        do_reset();
        wr(APrescale, 32'hFFFF_0003, 4'hF);
        rd("presc_rb", APrescale, 32'd3);
        wr(ACtrl, 32'h1, 4'hF);
        repeat (12) @(posedge clk_i);
        #1;
        rd("presc_mtime", AMtimeLo, 32'd3);
        wr(ACtrl, 32'h0, 4'hF);
`else
        unmapped("presc_rd14", 1'b0, APrescale);
        unmapped("presc_wr14", 1'b1, APrescale);
`endif

        // Reset mid-count with a request pending
        do_reset();
        wr(AMtimecmpLo, 32'h0, 4'hF);
        wr(AMtimecmpHi, 32'h0, 4'hF);
        wr(ACtrl, 32'h1, 4'hF);
        repeat (3) @(posedge clk_i);
        #1;
        check("pre_rst_intr", {31'd0, timer_intr_o}, 32'd1);
        bus(1'b0, AMtimeLo, 4'h0, 32'h0, tmp_r, tmp_e);
        check("pre_rst_rdata_nz", {31'd0, (tmp_r != 32'd0)}, 32'd1);
        req_i  = 1'b1;
        addr_i = AMtimeLo;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        req_i  = 1'b0;
        rst_ni = 1'b1;
        check("mid_rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("mid_rst_rdata", rdata_o, 32'd0);
        check("mid_rst_err", {31'd0, err_o}, 32'd0);
        check("mid_rst_intr", {31'd0, timer_intr_o}, 32'd0);
        idle_cycle();
        rd("mid_rst_mtime", AMtimeLo, 32'd0);
        rd("mid_rst_ctrl", ACtrl, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
